// File: rtl/axis_video_pkg.sv
// axis_video_pkg: shared types and constants for the AXI-Stream video blocks.
//   DATA_W_DEF   default pixel width ({B,G,R}, 8 bits each)
//   fsm_t        frame arbiter state (IDLE / GRANT)
//   src_sel_t    1-bit source index (SRC0 / SRC1)
//   src_onehot   source index -> one-hot grant vector
//   src_other    the opposite source index (round-robin advance)
package axis_video_pkg;

   localparam int unsigned DATA_W_DEF = 24;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } fsm_t;

   typedef logic src_sel_t;

   localparam src_sel_t SRC0 = 1'b0;
   localparam src_sel_t SRC1 = 1'b1;

   function automatic logic [1:0] src_onehot(input src_sel_t s);
      return (s == SRC1) ? 2'b10 : 2'b01;
   endfunction

   function automatic src_sel_t src_other(input src_sel_t s);
      return (s == SRC1) ? SRC0 : SRC1;
   endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: single-register AXI-Stream output stage, 1-cycle latency.
// The input is ready whenever the register is empty or being drained, so a
// continuous stream passes at full throughput without bubbles.
//   aclk, aresetn   clock, async active-low reset
//   in_valid/in_ready/in_data     upstream handshake and payload (W bits)
//   out_valid/out_ready/out_data  downstream handshake and payload (W bits)
module axis_reg_slice #(
   parameter int unsigned W = 26
) (
   input  logic         aclk,
   input  logic         aresetn,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic accept;

   assign in_ready = out_ready || !out_valid;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/axis_frame_arbiter_2to1.sv
// axis_frame_arbiter_2to1: frame-granular 2:1 AXI-Stream arbiter feeding one
// RGB->grayscale core. A source is granted from its SOF (tuser) beat until the
// LINES_PER_FRAME-th accepted tlast, then arbitration is redone round-robin.
// Optional watchdog (FRAME_ARB_TIMEOUT_EN) releases a grant whose source stalls.
//   aclk, aresetn                 clock, async active-low reset
//   s0_axis_*, s1_axis_*          source streams (tvalid/tready/tdata/tlast/tuser)
//   m_axis_*                      registered output stream to the grayscale core
//   grant                         one-hot granted source, 2'b00 when idle
//   frame_done                    pulse: final tlast of granted frame accepted
//   sof_err                       pulse: tuser on a non-first beat (frame restart)
//   timeout_err                   pulse: watchdog released the grant (0 if disabled)
module axis_frame_arbiter_2to1
   import axis_video_pkg::*;
#(
   parameter int unsigned DATA_W          = DATA_W_DEF,
   parameter int unsigned LINES_PER_FRAME = 480,
   parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
   input  logic              aclk,
   input  logic              aresetn,

   input  logic              s0_axis_tvalid,
   output logic              s0_axis_tready,
   input  logic [DATA_W-1:0] s0_axis_tdata,
   input  logic              s0_axis_tlast,
   input  logic              s0_axis_tuser,

   input  logic              s1_axis_tvalid,
   output logic              s1_axis_tready,
   input  logic [DATA_W-1:0] s1_axis_tdata,
   input  logic              s1_axis_tlast,
   input  logic              s1_axis_tuser,

   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tlast,
   output logic              m_axis_tuser,

   output logic [1:0]        grant,
   output logic              frame_done,
   output logic              sof_err,
   output logic              timeout_err
);

   localparam int unsigned CNT_W = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
   localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(LINES_PER_FRAME - 1);

   fsm_t              state, next_state;
   src_sel_t          cur_src, rr_ptr, pick;
   logic              first_beat;
   logic [CNT_W-1:0]  line_cnt, eff_cnt;

   logic              req0, req1;
   logic              sel_tvalid, sel_tready;
   logic [DATA_W-1:0] sel_tdata;
   logic              sel_tlast, sel_tuser;
   logic              accept, restart, frame_end, timeout_hit;
   logic [DATA_W+1:0] m_payload;

   // ------------------------------------------------------------------
   // Arbitration request decode
   // ------------------------------------------------------------------
   assign req0 = s0_axis_tvalid && s0_axis_tuser;
   assign req1 = s1_axis_tvalid && s1_axis_tuser;

   always_comb begin
      if (req0 && req1) pick = rr_ptr;
      else if (req1)    pick = SRC1;
      else              pick = SRC0;
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= IDLE;
      else          state <= next_state;
   end

   // ------------------------------------------------------------------
   // FSM: next-state and frame events
   // ------------------------------------------------------------------
   always_comb begin
      accept    = sel_tvalid && sel_tready;
      // A mid-frame SOF restarts the line count before its own tlast is counted.
      restart   = accept && sel_tuser && !first_beat;
      eff_cnt   = restart ? '0 : line_cnt;
      frame_end = accept && sel_tlast && (eff_cnt == LAST_LINE);
      next_state = state;
      case (state)
         IDLE:    if (req0 || req1) next_state = GRANT;
         GRANT:   if (frame_end || timeout_hit) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs (tready steering and source mux)
   // ------------------------------------------------------------------
   always_comb begin
      s0_axis_tready = 1'b0;
      s1_axis_tready = 1'b0;
      sel_tvalid     = 1'b0;
      sel_tdata      = s0_axis_tdata;
      sel_tlast      = s0_axis_tlast;
      sel_tuser      = s0_axis_tuser;
      case (state)
         IDLE: begin
            // Beats without SOF are drained so a source cannot block arbitration
            // with a partial frame; SOF beats are held for the grant.
            s0_axis_tready = s0_axis_tvalid && !s0_axis_tuser;
            s1_axis_tready = s1_axis_tvalid && !s1_axis_tuser;
         end
         GRANT: begin
            if (cur_src == SRC1) begin
               s1_axis_tready = sel_tready;
               sel_tvalid     = s1_axis_tvalid;
               sel_tdata      = s1_axis_tdata;
               sel_tlast      = s1_axis_tlast;
               sel_tuser      = s1_axis_tuser;
            end else begin
               s0_axis_tready = sel_tready;
               sel_tvalid     = s0_axis_tvalid;
            end
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Grant, line counter, round-robin pointer, event pulses
   // ------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cur_src    <= SRC0;
         rr_ptr     <= SRC0;
         grant      <= 2'b00;
         first_beat <= 1'b0;
         line_cnt   <= '0;
         frame_done <= 1'b0;
         sof_err    <= 1'b0;
      end else begin
         frame_done <= frame_end;
         sof_err    <= restart;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  cur_src    <= pick;
                  grant      <= src_onehot(pick);
                  first_beat <= 1'b1;
                  line_cnt   <= '0;
               end
            end
            GRANT: begin
               if (accept) first_beat <= 1'b0;
               if (frame_end || timeout_hit) begin
                  grant    <= 2'b00;
                  rr_ptr   <= src_other(cur_src);
                  line_cnt <= '0;
               end else if (accept && sel_tlast) begin
                  line_cnt <= eff_cnt + CNT_W'(1);
               end else if (restart) begin
                  line_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Optional stall watchdog
   // ------------------------------------------------------------------
`ifdef FRAME_ARB_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] stall_cnt;

   // Fires on the TIMEOUT_CYCLES-th consecutive cycle without a valid beat.
   assign timeout_hit = (state == GRANT) && !sel_tvalid && (stall_cnt == TO_LAST);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         stall_cnt   <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= timeout_hit;
         if ((state != GRANT) || accept || timeout_hit) stall_cnt <= '0;
         else if (!sel_tvalid)                           stall_cnt <= stall_cnt + TO_W'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Registered output stage
   // ------------------------------------------------------------------
   axis_reg_slice #(
      .W (DATA_W + 2)
   ) u_out_slice (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .in_valid  (sel_tvalid),
      .in_ready  (sel_tready),
      .in_data   ({sel_tuser, sel_tlast, sel_tdata}),
      .out_valid (m_axis_tvalid),
      .out_ready (m_axis_tready),
      .out_data  (m_payload)
   );

   assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = m_payload;

endmodule

// File: tb/tb_axis_frame_arbiter_2to1.sv
// tb_axis_frame_arbiter_2to1: scoreboard bench for the 2:1 frame arbiter
// (LINES_PER_FRAME=4, TIMEOUT_CYCLES=16, 2 beats per line).
module tb_axis_frame_arbiter_2to1;

   localparam int unsigned DW       = 24;
   localparam int unsigned LINES    = 4;
   localparam int unsigned TO_CYC   = 16;
   localparam int          HS_LIMIT = 200;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          s0_axis_tvalid = 1'b0, s0_axis_tready;
   logic [DW-1:0] s0_axis_tdata = '0;
   logic          s0_axis_tlast = 1'b0, s0_axis_tuser = 1'b0;
   logic          s1_axis_tvalid = 1'b0, s1_axis_tready;
   logic [DW-1:0] s1_axis_tdata = '0;
   logic          s1_axis_tlast = 1'b0, s1_axis_tuser = 1'b0;
   logic          m_axis_tvalid, m_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tlast, m_axis_tuser;
   logic [1:0]    grant;
   logic          frame_done, sof_err, timeout_err;

   axis_frame_arbiter_2to1 #(
      .DATA_W          (DW),
      .LINES_PER_FRAME (LINES),
      .TIMEOUT_CYCLES  (TO_CYC)
   ) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .s0_axis_tvalid (s0_axis_tvalid),
      .s0_axis_tready (s0_axis_tready),
      .s0_axis_tdata  (s0_axis_tdata),
      .s0_axis_tlast  (s0_axis_tlast),
      .s0_axis_tuser  (s0_axis_tuser),
      .s1_axis_tvalid (s1_axis_tvalid),
      .s1_axis_tready (s1_axis_tready),
      .s1_axis_tdata  (s1_axis_tdata),
      .s1_axis_tlast  (s1_axis_tlast),
      .s1_axis_tuser  (s1_axis_tuser),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tlast   (m_axis_tlast),
      .m_axis_tuser   (m_axis_tuser),
      .grant          (grant),
      .frame_done     (frame_done),
      .sof_err        (sof_err),
      .timeout_err    (timeout_err)
   );

   always #5 aclk = ~aclk;

   int n_vec = 0;
   int n_err = 0;
   logic [25:0] exp_q[$];

   bit toggle_rdy = 1'b0;
   bit abort = 1'b0;
   int cyc = 0;
   int src_tl = 0;
   int exp_lines = LINES;
   int n_done = 0, n_sof = 0, n_to = 0, n_to_total = 0;
   bit seen_in_sof = 1'b0, seen_out_sof = 1'b0;
   int in_sof_cyc = 0, out_sof_cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] bdata(input int src, input int fid, input int idx);
      return {8'(8'hA0 + src), 8'(fid), 8'(idx)};
   endfunction

   function automatic logic src_ready(input int src);
      return (src == 0) ? s0_axis_tready : s1_axis_tready;
   endfunction

   task automatic drive_src(input int src, input logic v, input logic [DW-1:0] d,
                            input logic l, input logic u);
      if (src == 0) begin
         s0_axis_tvalid = v; s0_axis_tdata = d; s0_axis_tlast = l; s0_axis_tuser = u;
      end else begin
         s1_axis_tvalid = v; s1_axis_tdata = d; s1_axis_tlast = l; s1_axis_tuser = u;
      end
   endtask

   // Returns just after the edge on which the presented beat was taken.
   task automatic wait_hs(input int src);
      int n;
      n = 0;
      forever begin
         @(negedge aclk);
         if (abort) return;
         if (src_ready(src)) begin
            @(posedge aclk);
            #1;
            return;
         end
         n++;
         if (n >= HS_LIMIT) begin
            check("src_hs_wait", {31'd0, src_ready(src)}, 32'd1);
            return;
         end
      end
   endtask

   // Beat idx = line*2 + b; tlast on b==1; tuser on beat 0 and on the first
   // beat of restart_line (if > 0). stop_after >= 0 truncates the frame.
   task automatic push_frame(input int src, input int fid, input int nlines,
                             input int restart_line, input int stop_after);
      for (int ln = 0; ln < nlines; ln++) begin
         if (stop_after >= 0 && ln >= stop_after) break;
         for (int b = 0; b < 2; b++) begin
            logic u;
            u = (ln == 0 && b == 0) || (restart_line > 0 && ln == restart_line && b == 0);
            exp_q.push_back({u, (b == 1), bdata(src, fid, ln * 2 + b)});
         end
      end
   endtask

   task automatic send_frame(input int src, input int fid, input int nlines,
                             input int restart_line, input int stop_after);
      for (int ln = 0; ln < nlines; ln++) begin
         if (stop_after >= 0 && ln >= stop_after) break;
         for (int b = 0; b < 2; b++) begin
            logic u;
            u = (ln == 0 && b == 0) || (restart_line > 0 && ln == restart_line && b == 0);
            if (abort) begin
               drive_src(src, 1'b0, '0, 1'b0, 1'b0);
               return;
            end
            drive_src(src, 1'b1, bdata(src, fid, ln * 2 + b), (b == 1), u);
            wait_hs(src);
         end
      end
      drive_src(src, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic send_garbage(input int src, input int n);
      for (int i = 0; i < n; i++) begin
         drive_src(src, 1'b1, 24'hDEAD00 | 24'(i), 1'b0, 1'b0);
         wait_hs(src);
      end
      drive_src(src, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      aresetn    = 1'b0;
      toggle_rdy = 1'b0;
      m_axis_tready = 1'b1;
      drive_src(0, 1'b0, '0, 1'b0, 1'b0);
      drive_src(1, 1'b0, '0, 1'b0, 1'b0);
      repeat (3) @(posedge aclk);
      #1;
      exp_q.delete();
      abort = 1'b0;
      src_tl = 0; exp_lines = LINES;
      n_done = 0; n_sof = 0; n_to = 0;
      seen_in_sof = 1'b0; seen_out_sof = 1'b0;
      aresetn = 1'b1;
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || m_axis_tvalid) && n < 300) begin
         @(negedge aclk);
         n++;
      end
      check(tag, exp_q.size(), 0);
      repeat (2) @(negedge aclk);
   endtask

   // Output ready pattern: constant 1, or alternating when toggle_rdy is set.
   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge aclk);
         #1;
         if (toggle_rdy) m_axis_tready = ~m_axis_tready;
      end
   end

   // Monitor: handshakes complete on the following rising edge.
   always @(negedge aclk) begin
      if (aresetn) begin
         cyc++;
         if (frame_done) begin
            check("done_lines", src_tl, exp_lines);
            check("done_grant", {30'd0, grant}, 32'd0);
            n_done++;
            src_tl = 0;
         end
         if (sof_err) n_sof++;
         if (timeout_err) begin
            n_to++;
            n_to_total++;
            src_tl = 0;
         end
         if (s0_axis_tvalid && s0_axis_tready) begin
            if (s0_axis_tlast) src_tl++;
            if (s0_axis_tuser && !seen_in_sof) begin seen_in_sof = 1'b1; in_sof_cyc = cyc; end
         end
         if (s1_axis_tvalid && s1_axis_tready && s1_axis_tlast) src_tl++;
         if (m_axis_tvalid && m_axis_tuser && !seen_out_sof) begin
            seen_out_sof = 1'b1;
            out_sof_cyc  = cyc;
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) check("out_extra_beat", exp_q.size(), 1);
            else check("out_beat", {6'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {6'd0, exp_q.pop_front()});
         end
         if (grant == 2'b01 && s1_axis_tvalid) check("s1_stalled", {31'd0, s1_axis_tready}, 32'd0);
         if (grant == 2'b10 && s0_axis_tvalid) check("s0_stalled", {31'd0, s0_axis_tready}, 32'd0);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      do_reset();
      check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      check("rst_grant", {30'd0, grant}, 32'd0);
      check("rst_pulses", {29'd0, frame_done, sof_err, timeout_err}, 32'd0);

      // 1: single s0 frame, full throughput
      push_frame(0, 1, LINES, -1, -1);
      fork
         send_frame(0, 1, LINES, -1, -1);
         begin
            int n;
            n = 0;
            while (grant == 2'b00 && n < 20) begin @(negedge aclk); n++; end
            check("t1_grant", {30'd0, grant}, 32'd1);
         end
      join
      wait_drain("t1_drain");
      check("t1_latency", out_sof_cyc - in_sof_cyc, 1);
      check("t1_done", n_done, 1);
      check("t1_grant_idle", {30'd0, grant}, 32'd0);

      // 2: simultaneous SOF after reset -> s0 first, then s1
      do_reset();
      push_frame(0, 2, LINES, -1, -1);
      push_frame(1, 2, LINES, -1, -1);
      fork
         send_frame(0, 2, LINES, -1, -1);
         send_frame(1, 2, LINES, -1, -1);
      join
      wait_drain("t2_drain");
      check("t2_done", n_done, 2);

      // 3: garbage beats before SOF are drained
      do_reset();
      push_frame(1, 3, LINES, -1, -1);
      send_garbage(1, 3);
      send_frame(1, 3, LINES, -1, -1);
      wait_drain("t3_drain");
      check("t3_done", n_done, 1);

      // 4: alternating output backpressure
      do_reset();
      toggle_rdy = 1'b1;
      push_frame(0, 4, LINES, -1, -1);
      send_frame(0, 4, LINES, -1, -1);
      wait_drain("t4_drain");
      toggle_rdy = 1'b0;
      check("t4_done", n_done, 1);

      // 5: SOF on line 2 restarts the frame; done after 4 further tlasts
      do_reset();
      exp_lines = LINES + 1;
      push_frame(0, 5, LINES + 1, 1, -1);
      send_frame(0, 5, LINES + 1, 1, -1);
      wait_drain("t5_drain");
      check("t5_sof_err", n_sof, 1);
      check("t5_done", n_done, 1);

`ifdef FRAME_ARB_TIMEOUT_EN
      // 6: s0 stalls mid-frame while s1 requests -> watchdog hands over
      do_reset();
      push_frame(0, 6, LINES, -1, 1);
      push_frame(1, 6, LINES, -1, -1);
      fork
         send_frame(0, 6, LINES, -1, 1);
         begin
            repeat (2) @(posedge aclk);
            #1;
            send_frame(1, 6, LINES, -1, -1);
         end
         begin
            int n;
            n = 0;
            while (!timeout_err && n < HS_LIMIT) begin @(negedge aclk); n++; end
            check("t6_timeout_seen", {31'd0, timeout_err}, 32'd1);
            check("t6_grant_released", {30'd0, grant}, 32'd0);
            @(negedge aclk);
            check("t6_regrant_s1", {30'd0, grant}, 32'd2);
         end
      join
      wait_drain("t6_drain");
      check("t6_to_count", n_to, 1);
      check("t6_done", n_done, 1);
`endif

      // 7: reset mid-frame; rr pointer returns to source 0
      do_reset();
      push_frame(0, 7, LINES, -1, -1);
      send_frame(0, 7, LINES, -1, -1);
      wait_drain("t7_first_drain");
      push_frame(0, 8, LINES, -1, -1);
      fork
         send_frame(0, 8, LINES, -1, -1);
         begin
            repeat (4) @(negedge aclk);
            check("t7_pre_grant", {30'd0, grant}, 32'd1);
            check("t7_pre_valid", {31'd0, m_axis_tvalid}, 32'd1);
            #2;
            aresetn = 1'b0;
            abort   = 1'b1;
            #1;
            check("t7_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
            check("t7_rst_grant", {30'd0, grant}, 32'd0);
            exp_q.delete();
         end
      join
      do_reset();
      push_frame(0, 9, LINES, -1, -1);
      push_frame(1, 9, LINES, -1, -1);
      fork
         send_frame(0, 9, LINES, -1, -1);
         send_frame(1, 9, LINES, -1, -1);
      join
      wait_drain("t7_after_drain");
      check("t7_done", n_done, 2);

`ifndef FRAME_ARB_TIMEOUT_EN
      check("no_timeout", n_to_total, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
